serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial N-bit subtractor. It is the inverse-direction companion of the team's ripple full-adder carry logic: instead of combining operands through a carry chain, it computes A − B − Bin one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It sits beside the adder blocks as the area-minimal arithmetic unit. It uses a start/busy/done handshake for use by a sequential controller.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (≥2)

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on rising clk edge
- a  input  WIDTH  minuend, captured when start is accepted
- b  input  WIDTH  subtrahend, captured when start is accepted
- bin  input  1  borrow-in, captured when start is accepted
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse: result valid
- diff  output  WIDTH  A − B − Bin, modulo 2^WIDTH
- bout  output  1  final borrow-out (1 = unsigned underflow)
- ovf  output  1  signed (two's complement) overflow

## Operation
- Reset: every output is 0: busy, done, diff, bout, ovf. State is IDLE, the bit counter is 0, and the borrow FF is 0. Reset takes effect immediately, including mid-operation; any partial result is discarded.
- FSM states:
  - IDLE: wait for start.
  - RUN: process one bit per cycle.
  - DONE: one cycle with done=1.
- IDLE→RUN on start=1:
  - a and b are loaded into shift registers sa and sb.
  - The borrow FF is loaded with bin.
  - The counter is cleared.
  - Capture a[WIDTH-1] and b[WIDTH-1] for the ovf computation.
- RUN, per cycle, using x=sa[0], y=sb[0], br=borrow FF:
  - d = x ^ y ^ br
  - borrow_next = (~x & y) | (~x & br) | (y & br)
  - Shift d into the result register at its MSB, shifting right, so the result ends LSB-aligned after WIDTH shifts.
  - Shift sa and sb right; increment the counter.
- RUN→DONE when the WIDTH-th bit has been processed (counter == WIDTH-1 at that edge):
  - diff ← completed result register.
  - bout ← borrow_next.
  - ovf ← (a_msb ≠ b_msb) & (diff_msb ≠ a_msb).
- DONE→IDLE on the next edge, or DONE→RUN if start=1 in DONE (back-to-back).
- diff, bout and ovf hold their values until the next completed operation. They do not change during RUN; internal shift registers are separate from the output registers.
- start while in RUN: ignored, with no effect on the operation in progress.
- Widths:
  - The counter is clog2(WIDTH) bits.
  - Arithmetic wraps modulo 2^WIDTH.
  - bin participates as a borrow into bit 0.

## Timing
- Edge E0 samples start=1: busy=1 from E0.
- Edges E1…EW process bits 0…WIDTH-1.
- At EW: busy→0, done→1, and diff/bout/ovf update.
- At EW+1: done→0.
- Latency from start sampled to done visible is WIDTH clocks; throughput is one operation per WIDTH+1 clocks.
- A back-to-back start held high through DONE is accepted at EW+1, so busy is high again from EW+1.
- busy and done are never high together.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, a=0x05, b=0x03, bin=0, one-cycle start → after 8 clocks done pulses once; diff=0x02, bout=0, ovf=0; busy was high exactly 8 cycles.
- a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1, ovf=0. Then a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1.
- a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF → diff=0x80, bout=1, ovf=1.
- Start pulsed again at bit 3 of a run with different operands → ignored; the result matches the first operands. Operands changed on the inputs mid-run → result unaffected.
- rst asserted asynchronously (between edges) at bit 4 → all outputs 0 immediately, state IDLE. A new start after rst drops completes correctly: 0x10−0x01 → 0x0F.
- start held high continuously for 3 operations → three done pulses spaced 9 clocks apart, each result correct. Also compare 500 random a/b/bin against the reference model (a−b−bin) mod 256, with bout equal to the borrow of the unsigned subtraction.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through one full-subtractor cell and a borrow flip-flop, with start/busy/done.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    // Only WIDTH-1 earlier result bits need storing; the newest bit joins at the MSB.
    logic [WIDTH-2:0] res_r;
    logic [CW-1:0]    cnt_r;
    logic             borrow_r;
    logic             a_msb_r;
    logic             b_msb_r;

    logic             d_s;
    logic             borrow_next_s;
    logic [WIDTH-1:0] res_next_s;
    logic             ovf_next_s;

    // Full-subtractor cell on the current LSB pair and the next result word
    always_comb begin
        d_s           = sa_r[0] ^ sb_r[0] ^ borrow_r;
        borrow_next_s = (~sa_r[0] & sb_r[0]) | (~sa_r[0] & borrow_r) | (sb_r[0] & borrow_r);
        res_next_s    = {d_s, res_r};
        ovf_next_s    = (a_msb_r ^ b_msb_r) & (res_next_s[WIDTH-1] ^ a_msb_r);
    end

    // Control FSM, operand shift registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            sa_r     <= {WIDTH{1'b0}};
            sb_r     <= {WIDTH{1'b0}};
            res_r    <= {(WIDTH-1){1'b0}};
            cnt_r    <= {CW{1'b0}};
            borrow_r <= 1'b0;
            a_msb_r  <= 1'b0;
            b_msb_r  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= {WIDTH{1'b0}};
            bout     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa_r     <= a;
                        sb_r     <= b;
                        borrow_r <= bin;
                        cnt_r    <= {CW{1'b0}};
                        res_r    <= {(WIDTH-1){1'b0}};
                        a_msb_r  <= a[WIDTH-1];
                        b_msb_r  <= b[WIDTH-1];
                        busy     <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    sa_r     <= {1'b0, sa_r[WIDTH-1:1]};
                    sb_r     <= {1'b0, sb_r[WIDTH-1:1]};
                    res_r    <= res_next_s[WIDTH-1:1];
                    borrow_r <= borrow_next_s;
                    cnt_r    <= cnt_r + CW'(1);
                    if (cnt_r == CNT_LAST) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        diff    <= res_next_s;
                        bout    <= borrow_next_s;
                        ovf     <= ovf_next_s;
                        state_r <= DONE;
                    end else begin
                        busy <= 1'b1;
                        done <= 1'b0;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: a cycle-timed arithmetic model
// checked every cycle, plus directed literal expectations.
module tb_serial_subtractor;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = 8'h00;
    logic [W-1:0] b = 8'h00;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // model state: cycles since acceptance (-1 = no operation)
    int           phase = -1;
    logic [W-1:0] pend_diff = 8'h00;
    logic         pend_bout = 1'b0;
    logic         pend_ovf = 1'b0;
    logic         exp_busy = 1'b0;
    logic         exp_done = 1'b0;
    logic [W-1:0] exp_diff = 8'h00;
    logic         exp_bout = 1'b0;
    logic         exp_ovf = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                                    output logic [W-1:0] d, output logic bo, output logic ov);
        int u;
        int s;
        u  = int'(x) - int'(y) - int'(bi);
        s  = int'($signed(x)) - int'($signed(y)) - int'(bi);
        d  = W'(u);
        bo = (u < 0);
        ov = (s < -128) || (s > 127);
    endfunction

    // Reference model: a request is accepted when nothing runs or in the done cycle;
    // the result appears W cycles later for exactly one cycle.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                phase = -1;
                exp_diff = 8'h00;
                exp_bout = 1'b0;
                exp_ovf = 1'b0;
            end else if (phase >= 0 && phase < W) begin
                phase++;
                if (phase == W) begin
                    exp_diff = pend_diff;
                    exp_bout = pend_bout;
                    exp_ovf = pend_ovf;
                end
            end else if (start) begin
                ref_sub(a, b, bin, pend_diff, pend_bout, pend_ovf);
                phase = 0;
            end else begin
                phase = -1;
            end
            exp_busy = (phase >= 0 && phase < W);
            exp_done = (phase == W);
        end
    end

    // Compare process: every output on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            check("busy_done_excl", 32'(busy & done), 32'd0);
            check("diff", 32'(diff), 32'(exp_diff));
            check("bout", 32'(bout), 32'(exp_bout));
            check("ovf", 32'(ovf), 32'(exp_ovf));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(output int busy_cnt);
        int k;
        busy_cnt = 0;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            if (busy === 1'b1) busy_cnt++;
            step();
            k++;
        end
        if (k >= 40) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                          input logic [W-1:0] ed, input logic eb, input logic eo, input string tag);
        int bc;
        a = x; b = y; bin = bi; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(bc);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_bout"}, 32'(bout), 32'(eb));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        check({tag, "_busycycles"}, 32'(bc), 32'd8);
        step();
        check({tag, "_donepulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [W-1:0] md;
        logic mb;
        logic mo;
        int bc;
        int d1;
        int d2;
        int d3;

        // pin the model with hand-computed values
        ref_sub(8'h05, 8'h03, 1'b0, md, mb, mo);
        check("model_05_03", {23'd0, mo, mb, md}, {23'd0, 1'b0, 1'b0, 8'h02});
        ref_sub(8'h03, 8'h05, 1'b0, md, mb, mo);
        check("model_03_05", {23'd0, mo, mb, md}, {23'd0, 1'b0, 1'b1, 8'hFE});
        ref_sub(8'h7F, 8'hFF, 1'b0, md, mb, mo);
        check("model_7f_ff", {23'd0, mo, mb, md}, {23'd0, 1'b1, 1'b1, 8'h80});

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {27'd0, busy, done, bout, ovf, 1'b0} | 32'(diff), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "t05_03");
        run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, "t03_05");
        run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "t00_00_b");
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "t80_01");
        run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "t7f_ff");

        // start and operand changes mid-run are ignored
        a = 8'h40; b = 8'h11; bin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        a = 8'hAA; b = 8'h55; bin = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        a = 8'h01; b = 8'h02;
        wait_done(bc);
        check("midrun_diff", 32'(diff), 32'h2F);
        check("midrun_bout", 32'(bout), 32'd0);
        step();

        // asynchronous reset during bit 4
        a = 8'h99; b = 8'h11; bin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        #1 rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_outs", {29'd0, done, bout, ovf} | 32'(diff), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, "after_rst");

        // start held high for three back-to-back operations
        a = 8'h55; b = 8'h22; bin = 1'b0; start = 1'b1;
        step();
        wait_done(bc);
        d1 = cyc;
        check("b2b1_diff", 32'(diff), 32'h33);
        a = 8'h22; b = 8'h55; bin = 1'b1;
        step();
        check("b2b_busy_again", 32'(busy), 32'd1);
        wait_done(bc);
        d2 = cyc;
        check("b2b2_diff", {23'd0, bout, diff}, {23'd0, 1'b1, 8'hCC});
        a = 8'h90; b = 8'h10; bin = 1'b0;
        step();
        wait_done(bc);
        d3 = cyc;
        start = 1'b0;
        check("b2b3_diff", {22'd0, ovf, bout, diff}, {22'd0, 1'b0, 1'b0, 8'h80});
        check("b2b_space12", 32'(d2 - d1), 32'd9);
        check("b2b_space23", 32'(d3 - d2), 32'd9);
        step();
        step();

        // randomized operations, occasionally back-to-back
        for (int i = 0; i < 500; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            bin = 1'($urandom);
            start = 1'b1;
            step();
            start = 1'b0;
            wait_done(bc);
            if ($urandom_range(0, 3) == 0) begin
                a = 8'($urandom);
                b = 8'($urandom);
                bin = 1'($urandom);
                start = 1'b1;
                step();
                start = 1'b0;
                wait_done(bc);
            end
            repeat ($urandom_range(1, 3)) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
